// File: rtl/cbfp1_block_scaler.sv
// cbfp1_block_scaler: CBFP stage-1 block-floating-point scaler.
// Each group of GROUP_CYC beats is normalised by its minimum leading-sign count.
// The group is buffered ping-pong and replayed as OUT_W-bit samples with exponent idx_out.
// Optional feature macro: CBFP1_ROUND_EN (round half-up plus saturation; default is floor truncation).
module cbfp1_block_scaler #(
    parameter  int unsigned N_LANE    = 16,
    parameter  int unsigned IN_W      = 23,
    parameter  int unsigned OUT_W     = 11,
    parameter  int unsigned GROUP_CYC = 4,
    localparam int unsigned IDX_W     = $clog2(IN_W)
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      mag_en,
    input  logic                      min_en,
    input  logic [N_LANE*IN_W-1:0]    din_re,
    input  logic [N_LANE*IN_W-1:0]    din_im,
    output logic [N_LANE*OUT_W-1:0]   dout_re,
    output logic [N_LANE*OUT_W-1:0]   dout_im,
    output logic                      dout_valid,
    output logic [IDX_W-1:0]          idx_out
);

    localparam int unsigned SH     = IN_W - OUT_W;
    localparam int unsigned RW     = IN_W + 1;
    localparam int unsigned CNT_W  = (GROUP_CYC > 1) ? $clog2(GROUP_CYC) : 1;
    localparam int unsigned BUS_I  = N_LANE * IN_W;
    localparam int unsigned BUS_O  = N_LANE * OUT_W;

    localparam logic [IDX_W-1:0] LSC_MAX  = IDX_W'(IN_W - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GROUP_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_READ = 1'b1;

    // Leading-sign count: bits below the MSB that equal the MSB.
    function automatic logic [IDX_W-1:0] lsc(input logic [IN_W-1:0] x);
        logic [IDX_W-1:0] n;
        logic             done;
        n    = '0;
        done = 1'b0;
        for (int i = IN_W - 2; i >= 0; i--) begin
            if (!done && (x[i] == x[IN_W-1])) begin
                n = n + IDX_W'(1);
            end else begin
                done = 1'b1;
            end
        end
        return n;
    endfunction

    // Left-normalise by the block exponent, then reduce to OUT_W bits.
    function automatic logic [OUT_W-1:0] normalise(input logic [IN_W-1:0] x,
                                                   input logic [IDX_W-1:0] sh);
        logic [IN_W-1:0] s;
`ifdef CBFP1_ROUND_EN
        logic [RW-1:0]   r;
        logic [OUT_W:0]  q;
`endif
        s = x << sh;
`ifdef CBFP1_ROUND_EN
        r = {s[IN_W-1], s} + (RW'(1) << (SH - 1));
        q = r[IN_W:SH];
        if (q[OUT_W] != q[OUT_W-1]) begin
            return q[OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end
        return q[OUT_W-1:0];
`else
        return s[IN_W-1:SH];
`endif
    endfunction

    // Ping-pong beat storage
    logic [BUS_I-1:0] bank_re [0:1][0:GROUP_CYC-1];
    logic [BUS_I-1:0] bank_im [0:1][0:GROUP_CYC-1];

    // Stage-1 state
    logic [CNT_W-1:0] wcnt;
    logic             wsel;
    logic             beat_bank;
    logic [IDX_W-1:0] beat_min;
    logic [IDX_W-1:0] beat_min_c;

    // Stage-2 state
    logic [CNT_W-1:0] gcnt;
    logic [IDX_W-1:0] acc;
    logic [IDX_W-1:0] grp_min_c;
    logic [IDX_W-1:0] exp_pend;
    logic             rsel;
    logic             rd_pending;
    logic             grp_done_c;

    // Readout FSM
    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic [CNT_W-1:0] rcnt;
    logic [CNT_W-1:0] rcnt_nxt;
    logic             emit_c;
    logic             pend_clr_c;
    logic [CNT_W-1:0] rd_idx_c;
    logic [IDX_W-1:0] rd_exp_c;
    logic [BUS_I-1:0] rd_re_c;
    logic [BUS_I-1:0] rd_im_c;
    logic [BUS_O-1:0] norm_re_c;
    logic [BUS_O-1:0] norm_im_c;

    // Per-beat minimum leading-sign count over every re/im lane
    always_comb begin
        beat_min_c = LSC_MAX;
        for (int l = 0; l < int'(N_LANE); l++) begin
            if (lsc(din_re[l*IN_W +: IN_W]) < beat_min_c) begin
                beat_min_c = lsc(din_re[l*IN_W +: IN_W]);
            end
            if (lsc(din_im[l*IN_W +: IN_W]) < beat_min_c) begin
                beat_min_c = lsc(din_im[l*IN_W +: IN_W]);
            end
        end
    end

    // Beat capture into the write bank; no reset needed on storage
    always_ff @(posedge clk) begin
        if (rstn && mag_en) begin
            bank_re[wsel][wcnt] <= din_re;
            bank_im[wsel][wcnt] <= din_im;
        end
    end

    // Stage 1: register beat minimum, advance write pointer, flip bank at group end
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wcnt      <= '0;
            wsel      <= 1'b0;
            beat_bank <= 1'b0;
            beat_min  <= '0;
        end else if (mag_en) begin
            beat_min  <= beat_min_c;
            beat_bank <= wsel;
            if (wcnt == CNT_LAST) begin
                wcnt <= '0;
                wsel <= ~wsel;
            end else begin
                wcnt <= wcnt + CNT_W'(1);
            end
        end
    end

    // Running group minimum and group-complete strobe
    always_comb begin
        grp_min_c  = ((gcnt == CNT_ZERO) || (beat_min < acc)) ? beat_min : acc;
        grp_done_c = min_en && (gcnt == CNT_LAST);
    end

    // Stage 2: accumulate minimum, latch exponent and hand finished bank to readout
    always_ff @(posedge clk) begin
        if (!rstn) begin
            gcnt       <= '0;
            acc        <= '0;
            exp_pend   <= '0;
            rsel       <= 1'b0;
            rd_pending <= 1'b0;
        end else begin
            if (min_en) begin
                acc <= grp_min_c;
                if (gcnt == CNT_LAST) begin
                    gcnt     <= '0;
                    exp_pend <= grp_min_c;
                    rsel     <= beat_bank;
                end else begin
                    gcnt <= gcnt + CNT_W'(1);
                end
            end
            if (grp_done_c) begin
                rd_pending <= 1'b1;
            end else if (pend_clr_c) begin
                rd_pending <= 1'b0;
            end
        end
    end

    // Readout FSM state register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= S_IDLE;
            rcnt  <= '0;
        end else begin
            state <= state_nxt;
            rcnt  <= rcnt_nxt;
        end
    end

    // Readout FSM next state: beat 0 leaves IDLE, remaining beats stream from READ
    always_comb begin
        state_nxt  = state;
        rcnt_nxt   = rcnt;
        emit_c     = 1'b0;
        pend_clr_c = 1'b0;
        rd_idx_c   = rcnt;
        rd_exp_c   = idx_out;
        case (state)
            S_IDLE: begin
                rd_idx_c = '0;
                rd_exp_c = exp_pend;
                if (rd_pending) begin
                    emit_c     = 1'b1;
                    pend_clr_c = 1'b1;
                    if (GROUP_CYC > 1) begin
                        state_nxt = S_READ;
                        rcnt_nxt  = CNT_W'(1);
                    end
                end
            end
            S_READ: begin
                emit_c = 1'b1;
                if (rcnt == CNT_LAST) begin
                    state_nxt = S_IDLE;
                    rcnt_nxt  = '0;
                end else begin
                    rcnt_nxt = rcnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
                rcnt_nxt  = '0;
            end
        endcase
    end

    assign rd_re_c = bank_re[rsel][rd_idx_c];
    assign rd_im_c = bank_im[rsel][rd_idx_c];

    // Per-lane normalisation of the beat being read out
    always_comb begin
        norm_re_c = '0;
        norm_im_c = '0;
        for (int l = 0; l < int'(N_LANE); l++) begin
            norm_re_c[l*OUT_W +: OUT_W] = normalise(rd_re_c[l*IN_W +: IN_W], rd_exp_c);
            norm_im_c[l*OUT_W +: OUT_W] = normalise(rd_im_c[l*IN_W +: IN_W], rd_exp_c);
        end
    end

    // Output registers; data and exponent hold while not emitting
    always_ff @(posedge clk) begin
        if (!rstn) begin
            dout_re    <= '0;
            dout_im    <= '0;
            dout_valid <= 1'b0;
            idx_out    <= '0;
        end else begin
            dout_valid <= emit_c;
            if (emit_c) begin
                dout_re <= norm_re_c;
                dout_im <= norm_im_c;
                idx_out <= rd_exp_c;
            end
        end
    end

endmodule
